fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Sits directly upstream of the hazard unit and the decode stage.
  - Consumes StallF, StallD, FlushD and the execute-stage redirect (PCSrcE, PCTargetE).
  - Produces InstrD, PCD and PCPlus4D for decode, which supplies Rs1D/Rs2D back to the hazard unit.
- Talks to instruction memory over a request/grant/response handshake with one outstanding request.
- Holds a one-entry fetch buffer between the memory response and the IF/ID register.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register for a 5-stage RV32I core.
// A two-state request FSM keeps at most one instruction-memory request in flight.
// Each response lands in a one-entry fetch buffer, which then drains into IF/ID.
// A redirect from execute discards the buffered instruction.
// It also kills any response that is still outstanding.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemGnt,
   input  logic        ImemRvalid,
   input  logic [31:0] ImemRdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Fetch-side state
   state_t      state_q;
   logic [31:0] pcf_q;
   logic [31:0] req_pc_q;
   logic        kill_q;
   logic        fb_valid_q;
   logic [31:0] fb_instr_q;
   logic [31:0] fb_pc_q;

   // IF/ID register
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q,    ifid_pc_d;
   logic [31:0] ifid_pc4_q,   ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic req_ok;
   logic handshake;
   logic fb_consume;

   // IF/ID drains the buffer only when decode is neither stalled nor flushed
   assign fb_consume = fb_valid_q & ~StallD & ~FlushD;

   // Request gating: a new fetch may issue only if the buffer will have room for its response
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      req_ok = 1'b0;
      if (state_q == S_REQ && !reset) begin
         req_ok = ~StallF & ~PCSrcE & (~fb_valid_q | fb_consume);
      end
   end

   assign handshake = req_ok & ImemGnt;
   assign ImemReq   = req_ok;
   assign ImemAddr  = pcf_q;

   // Request FSM, PC, kill flag and fetch buffer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_REQ;
         pcf_q      <= RESET_PC;
         req_pc_q   <= '0;
         kill_q     <= 1'b0;
         fb_valid_q <= 1'b0;
         fb_instr_q <= NOP_INSTR;
         fb_pc_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; a later assignment in this
         // block (such as the redirect below) overrides an earlier one in the same edge.
         if (fb_consume) begin
            fb_valid_q <= 1'b0;
         end
         case (state_q)
            S_REQ: begin
               // Responses seen here are stale (issued before reset) and are ignored
               if (handshake) begin
                  req_pc_q <= pcf_q;
                  pcf_q    <= pcf_q + 32'd4;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ImemRvalid) begin
                  state_q <= S_REQ;
                  kill_q  <= 1'b0;
                  if (!kill_q && !PCSrcE) begin
                     fb_instr_q <= ImemRdata;
                     fb_pc_q    <= req_pc_q;
                     fb_valid_q <= 1'b1;
                  end
               end else if (PCSrcE) begin
                  // Response still owed by memory belongs to the wrong path
                  kill_q <= 1'b1;
               end
            end
            default: state_q <= S_REQ;
         endcase
         if (PCSrcE) begin
            pcf_q      <= PCTargetE;
            fb_valid_q <= 1'b0;
         end
      end
   end

   // IF/ID next value: flush beats stall, stall beats load, otherwise bubble
   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (FlushD) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = '0;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end else if (StallD) begin
         ifid_instr_d = ifid_instr_q;
      end else if (fb_valid_q) begin
         ifid_instr_d = fb_instr_q;
         ifid_pc_d    = fb_pc_q;
         ifid_pc4_d   = fb_pc_q + 32'd4;
         ifid_valid_d = 1'b1;
      end else begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = '0;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign InstrD   = ifid_instr_q;
   assign PCD      = ifid_pc_q;
   assign PCPlus4D = ifid_pc4_q;
   assign ValidD   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// An instruction memory model grants requests and returns one response at a
// programmable latency, with the data a pure function of the address.
// A program-order model tracks the PC of the next instruction decode must see.
// Stalls must hold decode, and flushes must present a bubble.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemGnt = 1'b0, ImemRvalid = 1'b0;
   logic [31:0] ImemRdata = '0;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
      .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // memory model
   logic        pending = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_delay = 0;
   int          lat_max = 0;
   bit          force_stale = 1'b0;

   // program-order model
   logic [31:0] exp_pc = RESET_PC;

   // observations of the most recent cycle
   logic        obs_req, obs_gnt;
   logic [31:0] obs_addr;
   logic [31:0] grant_q[$];
   logic [31:0] del_pc_q[$];
   logic [31:0] del_p4_q[$];
   logic [31:0] del_instr_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return a ^ 32'h1357_9BD3;
   endfunction

   task automatic clear_logs();
      grant_q.delete();
      del_pc_q.delete();
      del_p4_q.delete();
      del_instr_q.delete();
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input logic sf, input logic sd, input logic fd, input logic ps,
                       input logic [31:0] tgt, input int gnt_pct);
      logic [31:0] h_instr, h_pc, h_p4;
      logic        h_valid, rv;
      StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
      if (force_stale) begin
         ImemRvalid = 1'b1; ImemRdata = 32'hDEAD_BEEF; force_stale = 1'b0;
      end else if (pending && pend_delay == 0) begin
         ImemRvalid = 1'b1; ImemRdata = mem_word(pend_addr);
      end else begin
         ImemRvalid = 1'b0; ImemRdata = $urandom;
      end
      ImemGnt = 1'b0;
      #1;
      obs_req = ImemReq; obs_addr = ImemAddr; obs_gnt = 1'b0;
      if (ImemReq) begin
         n_tests++;
         if (pending || sf || ps || ImemAddr[1:0] != 2'b00) begin
            n_fail++;
            $display("FAIL req_legal: ImemReq=1 addr=%h but outstanding=%0d StallF=%0d PCSrcE=%0d",
                     ImemAddr, pending, sf, ps);
         end
         obs_gnt = (int'($urandom_range(99)) < gnt_pct);
         ImemGnt = obs_gnt;
      end
      rv = ImemRvalid;
      h_instr = InstrD; h_pc = PCD; h_p4 = PCPlus4D; h_valid = ValidD;
      @(posedge clk); #1;
      ImemGnt = 1'b0; ImemRvalid = 1'b0;
      if (rv) pending = 1'b0;
      else if (pending) pend_delay--;
      if (obs_req && obs_gnt) begin
         pending = 1'b1; pend_addr = obs_addr;
         pend_delay = int'($urandom_range(lat_max));
         grant_q.push_back(obs_addr);
      end
      n_tests++;
      if (fd) begin
         if ({InstrD, ValidD, PCD, PCPlus4D} !== {NOP, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_bubble: got instr=%h valid=%0d pc=%h pc4=%h, want NOP/0/0/0",
                     InstrD, ValidD, PCD, PCPlus4D);
         end
      end else if (sd) begin
         if ({InstrD, ValidD, PCD, PCPlus4D} !== {h_instr, h_valid, h_pc, h_p4}) begin
            n_fail++;
            $display("FAIL stall_hold: got instr=%h valid=%0d pc=%h, want instr=%h valid=%0d pc=%h",
                     InstrD, ValidD, PCD, h_instr, h_valid, h_pc);
         end
      end else if (ValidD === 1'b1) begin
         if ({PCD, InstrD, PCPlus4D} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin
            n_fail++;
            $display("FAIL in_order: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                     PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
         end
         del_pc_q.push_back(PCD); del_p4_q.push_back(PCPlus4D); del_instr_q.push_back(InstrD);
         exp_pc = exp_pc + 32'd4;
      end else if (InstrD !== NOP) begin
         n_fail++;
         $display("FAIL empty_bubble: got instr=%h valid=%0d, want %h", InstrD, ValidD, NOP);
      end
      if (ps) exp_pc = tgt;
   endtask

   task automatic run_until_delivered(input int n, input int budget);
      for (int i = 0; i < budget && del_pc_q.size() < n; i++) step(0, 0, 0, 0, 32'h0, 100);
      n_tests++;
      if (del_pc_q.size() < n) begin
         n_fail++;
         $display("FAIL delivery_timeout: got %0d instructions, want %0d", del_pc_q.size(), n);
      end
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pending = 1'b0; exp_pc = RESET_PC;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      n_tests++;
      if ({InstrD, ValidD, PCD, PCPlus4D, ImemReq} !== {NOP, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got instr=%h valid=%0d pc=%h pc4=%h req=%0d", InstrD, ValidD, PCD, PCPlus4D, ImemReq);
      end
      release_reset();
   endtask

   task automatic test_basic();
      logic        r[5];
      logic [31:0] a[5], ins[5], pc[5], p4[5];
      logic        v[5];
      lat_max = 0;
      clear_logs();
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 0, 32'h0, 100);
         r[k] = obs_req; a[k] = obs_addr; ins[k] = InstrD; pc[k] = PCD; p4[k] = PCPlus4D; v[k] = ValidD;
      end
      n_tests++;
      if ({r[0], a[0]} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL first_req: got req=%0d addr=%h, want 1/0", r[0], a[0]); end
      n_tests++;
      if ({r[1], r[3]} !== 2'b00) begin n_fail++; $display("FAIL req_spacing: got req@1=%0d req@3=%0d, want 0/0", r[1], r[3]); end
      n_tests++;
      if ({r[2], a[2], r[4], a[4]} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
         n_fail++; $display("FAIL req_addr_seq: got %0d:%h %0d:%h, want 1:4 1:8", r[2], a[2], r[4], a[4]);
      end
      n_tests++;
      if ({ins[2], pc[2], p4[2], v[2]} !== {32'h0050_0093, 32'h0, 32'h4, 1'b1}) begin
         n_fail++; $display("FAIL first_instr: got %h pc=%h pc4=%h v=%0d, want 00500093 pc=0 pc4=4 v=1", ins[2], pc[2], p4[2], v[2]);
      end
      n_tests++;
      if ({ins[4], pc[4], p4[4], v[4]} !== {32'h0010_0113, 32'h4, 32'h8, 1'b1}) begin
         n_fail++; $display("FAIL second_instr: got %h pc=%h pc4=%h v=%0d, want 00100113 pc=4 pc4=8 v=1", ins[4], pc[4], p4[4], v[4]);
      end
   endtask

   task automatic test_stall();
      step(0, 0, 0, 0, 32'h0, 100);
      step(0, 0, 0, 0, 32'h0, 100);
      n_tests++;
      if ({InstrD, PCD} !== {mem_word(32'h8), 32'h8}) begin
         n_fail++; $display("FAIL stall_setup: got instr=%h pc=%h, want %h pc=8", InstrD, PCD, mem_word(32'h8));
      end
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 0, 32'h0, 100);
         n_tests++;
         if ({obs_req, InstrD, PCD} !== {1'b0, mem_word(32'h8), 32'h8}) begin
            n_fail++; $display("FAIL stall_cycle%0d: got req=%0d instr=%h pc=%h, want 0 %h pc=8", k, obs_req, InstrD, PCD, mem_word(32'h8));
         end
      end
      step(0, 0, 0, 0, 32'h0, 100);
      n_tests++;
      if ({InstrD, PCD, ValidD, obs_req, obs_addr} !== {mem_word(32'hC), 32'hC, 1'b1, 1'b1, 32'h10}) begin
         n_fail++; $display("FAIL stall_release: got instr=%h pc=%h v=%0d req=%0d addr=%h, want instr@C, req to 10",
                            InstrD, PCD, ValidD, obs_req, obs_addr);
      end
   endtask

   task automatic test_redirect();
      clear_logs();
      step(0, 0, 1, 1, 32'h40, 100);
      n_tests++;
      if ({obs_req, InstrD, ValidD} !== {1'b0, NOP, 1'b0}) begin
         n_fail++; $display("FAIL redirect_bubble: got req=%0d instr=%h v=%0d, want 0 NOP 0", obs_req, InstrD, ValidD);
      end
      step(0, 0, 0, 0, 32'h0, 100);
      n_tests++;
      if ({obs_req, obs_addr} !== {1'b1, 32'h40}) begin
         n_fail++; $display("FAIL redirect_addr: got req=%0d addr=%h, want 1/40", obs_req, obs_addr);
      end
      run_until_delivered(1, 8);
      if (del_pc_q.size() > 0) begin
         n_tests++;
         if ({del_pc_q[0], del_instr_q[0]} !== {32'h40, mem_word(32'h40)}) begin
            n_fail++; $display("FAIL redirect_target: got pc=%h instr=%h, want pc=40", del_pc_q[0], del_instr_q[0]);
         end
      end
   endtask

   task automatic test_gnt_hold();
      bit seen = 1'b0;
      step(0, 0, 1, 1, 32'h20, 100);
      for (int i = 0; i < 6 && !seen; i++) begin
         step(0, 0, 0, 0, 32'h0, 0);
         seen = obs_req;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL gnt_hold_req_timeout: got no request, want one to 00000020"); end
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 0, 32'h0, 0);
         n_tests++;
         if ({obs_req, obs_addr, ValidD} !== {1'b1, 32'h20, 1'b0}) begin
            n_fail++; $display("FAIL gnt_hold%0d: got req=%0d addr=%h v=%0d, want 1/20/0", k, obs_req, obs_addr, ValidD);
         end
      end
      clear_logs();
      run_until_delivered(1, 8);
      if (del_pc_q.size() > 0) begin
         n_tests++;
         if (del_pc_q[0] !== 32'h20) begin n_fail++; $display("FAIL gnt_hold_deliver: got pc=%h, want 00000020", del_pc_q[0]); end
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 1, 32'hFFFF_FFFC, 100);
      clear_logs();
      run_until_delivered(2, 20);
      if (grant_q.size() >= 2 && del_pc_q.size() >= 2) begin
         n_tests++;
         if ({grant_q[0], grant_q[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
            n_fail++; $display("FAIL wrap_addr: got %h then %h, want FFFFFFFC then 00000000", grant_q[0], grant_q[1]);
         end
         n_tests++;
         if ({del_pc_q[0], del_p4_q[0], del_pc_q[1]} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL wrap_pc4: got pc=%h pc4=%h next=%h, want FFFFFFFC/0/0", del_pc_q[0], del_p4_q[0], del_pc_q[1]);
         end
      end
   endtask

   task automatic test_async_reset();
      bit ready = 1'b0;
      lat_max = 0;
      for (int i = 0; i < 10 && !ready; i++) begin
         step(0, 0, 0, 0, 32'h0, 100);
         ready = pending && (ValidD === 1'b1);
      end
      n_tests++;
      if (!ready) begin n_fail++; $display("FAIL areset_setup: got no WAIT state with valid decode, want one"); end
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({InstrD, ValidD, PCD, PCPlus4D, ImemReq, ImemAddr} !== {NOP, 1'b0, 32'h0, 32'h0, 1'b0, RESET_PC}) begin
         n_fail++; $display("FAIL areset_immediate: got instr=%h v=%0d pc=%h pc4=%h req=%0d addr=%h",
                            InstrD, ValidD, PCD, PCPlus4D, ImemReq, ImemAddr);
      end
      release_reset();
      force_stale = 1'b1;
      clear_logs();
      run_until_delivered(1, 8);
      if (grant_q.size() > 0 && del_pc_q.size() > 0) begin
         n_tests++;
         if ({grant_q[0], del_pc_q[0], del_instr_q[0]} !== {RESET_PC, RESET_PC, mem_word(RESET_PC)}) begin
            n_fail++; $display("FAIL areset_restart: got addr=%h pc=%h instr=%h, want %h and %h",
                               grant_q[0], del_pc_q[0], del_instr_q[0], RESET_PC, mem_word(RESET_PC));
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      int          sel;
      lat_max = 2;
      clear_logs();
      for (int c = 0; c < 1500; c++) begin
         sel = int'($urandom_range(99));
         r   = $urandom;
         if (sel < 6) begin
            if (sel == 0) r = r | 32'hFFFF_FF00;
            step(0, 0, 1, 1, {r[31:2], 2'b00}, 70);
         end else if (sel < 20) step(1, 1, 0, 0, 32'h0, 70);
         else if (sel < 25)     step(0, 1, 0, 0, 32'h0, 70);
         else if (sel < 30)     step(1, 0, 0, 0, 32'h0, 70);
         else                   step(0, 0, 0, 0, 32'h0, 70);
      end
      n_tests++;
      if (del_pc_q.size() < 50) begin
         n_fail++; $display("FAIL random_progress: got %0d instructions, want at least 50", del_pc_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_gnt_hold();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
